// File: rtl/timer_input_pkg.sv
// Shared types and sizing helpers for the timer input conditioner.
package timer_input_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    function automatic int calc_tick_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    function automatic int calc_div_width(input int tick_div);
        return (tick_div < 32'sd2) ? 32'sd1 : $clog2(tick_div);
    endfunction

    // Counter must hold the larger of the debounce and long-press targets.
    function automatic int calc_cnt_width(input int debounce_ticks, input int long_ticks);
        int max_v;
        max_v = (debounce_ticks > long_ticks) ? debounce_ticks : long_ticks;
        return (max_v < 32'sd1) ? 32'sd1 : $clog2(max_v + 32'sd1);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// One button path: 2-flop synchronizer, debounce FSM with tick counter,
// registered press pulse and optional long-hold pulse.
module button_debouncer
    import timer_input_pkg::*;
#(
    parameter int DEBOUNCE_TICKS   = 2,
    parameter int LONG_PRESS_TICKS = 100,
    parameter bit LONG_EN          = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw_in,
    output logic press_pulse,
    output logic long_pulse
);

    localparam int            CW       = calc_cnt_width(DEBOUNCE_TICKS, LONG_PRESS_TICKS);
    localparam logic [CW-1:0] DEB_CNT  = CW'(DEBOUNCE_TICKS);
    localparam logic [CW-1:0] LONG_CNT = CW'(LONG_PRESS_TICKS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    logic [1:0]    sync_q, sync_d;
    btn_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc_s;
    logic          press_q, press_d, long_q, long_d;
    logic          sync_s;

    assign sync_s      = sync_q[1];
    assign press_pulse = press_q;
    assign long_pulse  = long_q;

    // Next-state, counter and pulse logic for the debounce FSM.
    always_comb begin
        sync_d    = {sync_q[0], raw_in};
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        long_d    = 1'b0;
        cnt_inc_s = cnt_q + CNT_ONE;
        case (state_q)
            IDLE: begin
                if (sync_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = IDLE;
                end
            end
            PRESS_WAIT: begin
                if (!sync_s) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (tick) begin
                    if (cnt_inc_s == DEB_CNT) begin
                        state_d = HELD;
                        cnt_d   = CNT_ZERO;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            HELD: begin
                if (!sync_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ZERO;
                end else if (tick && (cnt_q < LONG_CNT)) begin
                    cnt_d  = cnt_inc_s;
                    long_d = LONG_EN && (cnt_inc_s == LONG_CNT);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back to high resumes the hold already past its long mark.
                if (sync_s) begin
                    state_d = HELD;
                    cnt_d   = LONG_CNT;
                end else if (tick) begin
                    if (cnt_inc_s == DEB_CNT) begin
                        state_d = IDLE;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State, synchronizer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            press_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            long_q  <= long_d;
        end
    end

endmodule

// File: rtl/timer_input_conditioner.sv
// Timer front end: free-running 100 Hz tick divider plus three debounced
// button paths producing single-cycle press pulses and a long-hold pulse.
module timer_input_conditioner
    import timer_input_pkg::*;
#(
    parameter int CLK_HZ           = 100_000_000,
    parameter int TICK_HZ          = 100,
    parameter int DEBOUNCE_TICKS   = 2,
    parameter int LONG_PRESS_TICKS = 100
) (
    input  logic clockSignal,
    input  logic resetSignalN,
    input  logic rawModeInput,
    input  logic rawStartOrStop,
    input  logic rawSplitOrReset,
    output logic tick100Hz,
    output logic modeInput,
    output logic startOrStop,
    output logic splitOrReset,
    output logic longPressSplitOrReset
);

    localparam int            TICK_DIV = calc_tick_div(CLK_HZ, TICK_HZ);
    localparam int            DW       = calc_div_width(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 32'sd1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(32'd1);

    logic [DW-1:0] div_q, div_d;
    logic          tick_q, tick_d;
    logic          mode_long_s, start_long_s, split_long_s;

    assign tick100Hz = tick_q;

    // Divider next state: wrap at TICK_DIV-1 and flag the tick for next cycle.
    always_comb begin
        tick_d = (div_q == DIV_LAST);
        if (tick_d) begin
            div_d = {DW{1'b0}};
        end else begin
            div_d = div_q + DIV_ONE;
        end
    end

    // Divider and tick registers.
    always_ff @(posedge clockSignal or negedge resetSignalN) begin
        if (!resetSignalN) begin
            div_q  <= {DW{1'b0}};
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    button_debouncer #(
        .DEBOUNCE_TICKS  (DEBOUNCE_TICKS),
        .LONG_PRESS_TICKS(LONG_PRESS_TICKS),
        .LONG_EN         (1'b0)
    ) u_mode (
        .clk        (clockSignal),
        .rst_n      (resetSignalN),
        .tick       (tick_q),
        .raw_in     (rawModeInput),
        .press_pulse(modeInput),
        .long_pulse (mode_long_s)
    );

    button_debouncer #(
        .DEBOUNCE_TICKS  (DEBOUNCE_TICKS),
        .LONG_PRESS_TICKS(LONG_PRESS_TICKS),
        .LONG_EN         (1'b0)
    ) u_start (
        .clk        (clockSignal),
        .rst_n      (resetSignalN),
        .tick       (tick_q),
        .raw_in     (rawStartOrStop),
        .press_pulse(startOrStop),
        .long_pulse (start_long_s)
    );

    button_debouncer #(
        .DEBOUNCE_TICKS  (DEBOUNCE_TICKS),
        .LONG_PRESS_TICKS(LONG_PRESS_TICKS),
        .LONG_EN         (1'b1)
    ) u_split (
        .clk        (clockSignal),
        .rst_n      (resetSignalN),
        .tick       (tick_q),
        .raw_in     (rawSplitOrReset),
        .press_pulse(splitOrReset),
        .long_pulse (split_long_s)
    );

    // Mode and start paths have long-press disabled, so their long outputs are constant zero.
    assign longPressSplitOrReset = split_long_s | mode_long_s | start_long_s;

endmodule
